// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite types: response codes and the byte-strobe merge of one data word.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  localparam int unsigned MaxDataWidth = 64;
  localparam int unsigned MaxStrbWidth = MaxDataWidth / 8;

  // Lanes with strb set take new_word; others keep old_word. Narrower words zero-extend in.
  function automatic logic [MaxDataWidth-1:0] strb_merge(
    input logic [MaxDataWidth-1:0] old_word,
    input logic [MaxDataWidth-1:0] new_word,
    input logic [MaxStrbWidth-1:0] strb
  );
    logic [MaxDataWidth-1:0] merged;
    for (int i = 0; i < int'(MaxStrbWidth); i++) begin
      merged[8*i +: 8] = strb[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/axi_lite_sub_wr.sv
// AXI-Lite write side: independent AW/W holding slots, commit, and B channel.
// Emits a one-cycle write strobe (enable/word index/data/strobe) toward the register bank.
module axi_lite_sub_wr
  import axi_lite_pkg::*;
#(
  parameter int unsigned ID_WIDTH   = 1,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned NUM_REGS   = 8
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [ID_WIDTH-1:0]   awid,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [STRB_WIDTH-1:0] wstrb,
  output logic                  bvalid,
  input  logic                  bready,
  output logic [ID_WIDTH-1:0]   bid,
  output logic [1:0]            bresp,
  output logic                  wr_en_o,
  output logic [ADDR_WIDTH-1:0] wr_idx_o,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  output logic [STRB_WIDTH-1:0] wr_strb_o
);

  localparam int unsigned AddrLsb = $clog2(STRB_WIDTH);

  logic                  aw_full_q, aw_full_d;
  logic [ID_WIDTH-1:0]   aw_id_q, aw_id_d;
  logic [ADDR_WIDTH-1:0] aw_idx_q, aw_idx_d;
  logic                  w_full_q, w_full_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [STRB_WIDTH-1:0] w_strb_q, w_strb_d;
  logic                  bvalid_q, bvalid_d;
  logic [ID_WIDTH-1:0]   bid_q, bid_d;
  resp_t                 bresp_q, bresp_d;
  logic                  commit;
  logic                  idx_ok;

  assign commit = aw_full_q && w_full_q && !bvalid_q;
  assign idx_ok = aw_idx_q < ADDR_WIDTH'(NUM_REGS);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      aw_full_q <= 1'b0;
      aw_id_q   <= '0;
      aw_idx_q  <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= OKAY;
    end else begin
      aw_full_q <= aw_full_d;
      aw_id_q   <= aw_id_d;
      aw_idx_q  <= aw_idx_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
    end
  end

  // Capture and commit never coincide on a slot: capture needs it empty, commit needs it full.
  always_comb begin
    aw_full_d = aw_full_q;
    aw_id_d   = aw_id_q;
    aw_idx_d  = aw_idx_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    if (awvalid && !aw_full_q) begin
      aw_full_d = 1'b1;
      aw_id_d   = awid;
      aw_idx_d  = awaddr >> AddrLsb;
    end
    if (wvalid && !w_full_q) begin
      w_full_d = 1'b1;
      w_data_d = wdata;
      w_strb_d = wstrb;
    end
    if (bvalid_q && bready) begin
      bvalid_d = 1'b0;
    end
    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bid_d     = aw_id_q;
      bresp_d   = idx_ok ? OKAY : SLVERR;
    end
  end

  always_comb begin
    awready   = !aw_full_q;
    wready    = !w_full_q;
    bvalid    = bvalid_q;
    bid       = bid_q;
    bresp     = bresp_q;
    wr_en_o   = commit && idx_ok;
    wr_idx_o  = aw_idx_q;
    wr_data_o = w_data_q;
    wr_strb_o = w_strb_q;
  end

endmodule

// File: rtl/axi_lite_sub_regs.sv
// AXI-Lite subordinate register bank: NUM_REGS byte-strobed RW words plus a read-only
// status word at index NUM_REGS; everything else answers SLVERR.
module axi_lite_sub_regs
  import axi_lite_pkg::*;
#(
  parameter int unsigned ID_WIDTH   = 1,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned NUM_REGS   = 8
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [ID_WIDTH-1:0]            awid,
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  input  logic [2:0]                     awprot,
  input  logic                           wvalid,
  output logic                           wready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [STRB_WIDTH-1:0]          wstrb,
  output logic                           bvalid,
  input  logic                           bready,
  output logic [ID_WIDTH-1:0]            bid,
  output logic [1:0]                     bresp,
  input  logic                           arvalid,
  output logic                           arready,
  input  logic [ID_WIDTH-1:0]            arid,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  input  logic [2:0]                     arprot,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [ID_WIDTH-1:0]            rid,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]            wr_pulse_o,
  input  logic [DATA_WIDTH-1:0]          status_i
);

  localparam int unsigned AddrLsb = $clog2(STRB_WIDTH);

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_idx;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_WIDTH-1:0] wr_strb;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]   pulse_q, pulse_d;

  logic                  rvalid_q, rvalid_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  resp_t                 rresp_q, rresp_d;
  logic [ADDR_WIDTH-1:0] ar_idx;
  logic [DATA_WIDTH-1:0] rd_data;
  resp_t                 rd_resp;

  logic unused_prot;
  assign unused_prot = ^{awprot, arprot};

  axi_lite_sub_wr #(
    .ID_WIDTH   (ID_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .STRB_WIDTH (STRB_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_wr (
    .aclk      (aclk),
    .areset    (areset),
    .awvalid   (awvalid),
    .awready   (awready),
    .awid      (awid),
    .awaddr    (awaddr),
    .wvalid    (wvalid),
    .wready    (wready),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .bvalid    (bvalid),
    .bready    (bready),
    .bid       (bid),
    .bresp     (bresp),
    .wr_en_o   (wr_en),
    .wr_idx_o  (wr_idx),
    .wr_data_o (wr_data),
    .wr_strb_o (wr_strb)
  );

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int k = 0; k < int'(NUM_REGS); k++) begin
        regs_q[k] <= '0;
      end
      pulse_q  <= '0;
      rvalid_q <= 1'b0;
      rid_q    <= '0;
      rdata_q  <= '0;
      rresp_q  <= OKAY;
    end else begin
      for (int k = 0; k < int'(NUM_REGS); k++) begin
        regs_q[k] <= regs_d[k];
      end
      pulse_q  <= pulse_d;
      rvalid_q <= rvalid_d;
      rid_q    <= rid_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end
  end

  always_comb begin
    pulse_d = '0;
    for (int k = 0; k < int'(NUM_REGS); k++) begin
      regs_d[k] = regs_q[k];
      if (wr_en && (wr_idx == ADDR_WIDTH'(k))) begin
        regs_d[k]  = DATA_WIDTH'(strb_merge(MaxDataWidth'(regs_q[k]), MaxDataWidth'(wr_data),
                                            MaxStrbWidth'(wr_strb)));
        pulse_d[k] = 1'b1;
      end
    end
  end

  // Read decode uses pre-edge register contents, so a same-edge commit is not visible.
  always_comb begin
    ar_idx  = araddr >> AddrLsb;
    rd_data = '0;
    rd_resp = SLVERR;
    for (int k = 0; k < int'(NUM_REGS); k++) begin
      if (ar_idx == ADDR_WIDTH'(k)) begin
        rd_data = regs_q[k];
        rd_resp = OKAY;
      end
    end
    if (ar_idx == ADDR_WIDTH'(NUM_REGS)) begin
      rd_data = status_i;
      rd_resp = OKAY;
    end
  end

  always_comb begin
    rvalid_d = rvalid_q;
    rid_d    = rid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (rvalid_q && rready) begin
      rvalid_d = 1'b0;
    end
    if (arvalid && !rvalid_q) begin
      rvalid_d = 1'b1;
      rid_d    = arid;
      rdata_d  = rd_data;
      rresp_d  = rd_resp;
    end
  end

  for (genvar g = 0; g < int'(NUM_REGS); g++) begin : g_regs_out
    assign regs_o[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
  end

  always_comb begin
    wr_pulse_o = pulse_q;
    arready    = !rvalid_q;
    rvalid     = rvalid_q;
    rid        = rid_q;
    rdata      = rdata_q;
    rresp      = rresp_q;
  end

endmodule

// File: tb/tb_axi_lite_sub_regs.sv
// Directed bench for axi_lite_sub_regs: hand-computed expectations, one checking task.
module tb_axi_lite_sub_regs;

  localparam int unsigned IW = 1;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned NR = 8;

  logic              aclk = 1'b0;
  logic              areset = 1'b1;
  logic              awvalid = 1'b0, awready;
  logic [IW-1:0]     awid = '0;
  logic [AW-1:0]     awaddr = '0;
  logic [2:0]        awprot = '0;
  logic              wvalid = 1'b0, wready;
  logic [DW-1:0]     wdata = '0;
  logic [SW-1:0]     wstrb = '0;
  logic              bvalid, bready = 1'b0;
  logic [IW-1:0]     bid;
  logic [1:0]        bresp;
  logic              arvalid = 1'b0, arready;
  logic [IW-1:0]     arid = '0;
  logic [AW-1:0]     araddr = '0;
  logic [2:0]        arprot = '0;
  logic              rvalid, rready = 1'b0;
  logic [IW-1:0]     rid;
  logic [DW-1:0]     rdata;
  logic [1:0]        rresp;
  logic [NR*DW-1:0]  regs_o;
  logic [NR-1:0]     wr_pulse_o;
  logic [DW-1:0]     status_i = '0;

  int unsigned total = 0;
  int unsigned bad = 0;
  logic [DW-1:0] exp_regs [NR];

  axi_lite_sub_regs #(
    .ID_WIDTH   (IW),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .STRB_WIDTH (SW),
    .NUM_REGS   (NR)
  ) dut (
    .aclk       (aclk),
    .areset     (areset),
    .awvalid    (awvalid),
    .awready    (awready),
    .awid       (awid),
    .awaddr     (awaddr),
    .awprot     (awprot),
    .wvalid     (wvalid),
    .wready     (wready),
    .wdata      (wdata),
    .wstrb      (wstrb),
    .bvalid     (bvalid),
    .bready     (bready),
    .bid        (bid),
    .bresp      (bresp),
    .arvalid    (arvalid),
    .arready    (arready),
    .arid       (arid),
    .araddr     (araddr),
    .arprot     (arprot),
    .rvalid     (rvalid),
    .rready     (rready),
    .rid        (rid),
    .rdata      (rdata),
    .rresp      (rresp),
    .regs_o     (regs_o),
    .wr_pulse_o (wr_pulse_o),
    .status_i   (status_i)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check_regs(input string tag);
    for (int k = 0; k < int'(NR); k++) begin
      check($sformatf("%s reg%0d", tag, k), 64'(regs_o[k*DW +: DW]), 64'(exp_regs[k]));
    end
  endtask

  // Drive AW and W together; both slots are expected empty, so one edge captures them.
  task automatic put_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s,
                        input logic [IW-1:0] id);
    awvalid = 1'b1; awaddr = a; awid = id;
    wvalid  = 1'b1; wdata = d;  wstrb = s;
    check("aw/w ready before put", 64'({awready, wready}), 64'b11);
    tick();
    awvalid = 1'b0;
    wvalid  = 1'b0;
  endtask

  task automatic accept_b();
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [IW-1:0] id);
    arvalid = 1'b1; araddr = a; arid = id;
    tick();
    arvalid = 1'b0;
  endtask

  task automatic accept_r();
    rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < int'(NR); k++) exp_regs[k] = '0;

    // Reset state
    tick();
    tick();
    check("rst awready", 64'(awready), 64'd1);
    check("rst wready", 64'(wready), 64'd1);
    check("rst arready", 64'(arready), 64'd1);
    check("rst bvalid", 64'(bvalid), 64'd0);
    check("rst rvalid", 64'(rvalid), 64'd0);
    check("rst wr_pulse", 64'(wr_pulse_o), 64'd0);
    check_regs("rst");
    areset = 1'b0;
    tick();

    // AW+W same cycle to reg1
    put_wr(32'h4, 32'hDEAD_BEEF, 4'hF, 1'b1);
    check("t1 bvalid early", 64'(bvalid), 64'd0);
    tick();
    exp_regs[1] = 32'hDEAD_BEEF;
    check("t1 bvalid", 64'(bvalid), 64'd1);
    check("t1 bid", 64'(bid), 64'd1);
    check("t1 bresp", 64'(bresp), 64'd0);
    check("t1 pulse", 64'(wr_pulse_o), 64'h02);
    check_regs("t1");
    tick();
    check("t1 pulse gone", 64'(wr_pulse_o), 64'h00);
    check("t1 bvalid hold", 64'(bvalid), 64'd1);
    accept_b();
    check("t1 bvalid clear", 64'(bvalid), 64'd0);

    // W three cycles before AW, partial strobe
    wvalid = 1'b1; wdata = 32'h0000_1234; wstrb = 4'h3;
    tick();
    wvalid = 1'b0;
    check("t2 wready after W", 64'(wready), 64'd0);
    tick();
    tick();
    awvalid = 1'b1; awaddr = 32'h4; awid = 1'b0;
    tick();
    awvalid = 1'b0;
    check("t2 no commit yet", 64'(bvalid), 64'd0);
    check("t2 reg1 old", 64'(regs_o[1*DW +: DW]), 64'hDEAD_BEEF);
    tick();
    exp_regs[1] = 32'hDEAD_1234;
    check("t2 bvalid", 64'(bvalid), 64'd1);
    check("t2 bid", 64'(bid), 64'd0);
    check("t2 pulse", 64'(wr_pulse_o), 64'h02);
    check_regs("t2");
    accept_b();

    // Status word and out-of-range accesses
    status_i = 32'h0000_A5A5;
    do_read(32'(4 * NR), 1'b1);
    check("t3 rvalid", 64'(rvalid), 64'd1);
    check("t3 arready low", 64'(arready), 64'd0);
    check("t3 rdata", 64'(rdata), 64'hA5A5);
    check("t3 rresp", 64'(rresp), 64'd0);
    check("t3 rid", 64'(rid), 64'd1);
    accept_r();
    check("t3 rvalid clear", 64'(rvalid), 64'd0);
    put_wr(32'(4 * NR), 32'hFFFF_FFFF, 4'hF, 1'b1);
    tick();
    check("t3 status wr bresp", 64'(bresp), 64'd2);
    check("t3 status wr pulse", 64'(wr_pulse_o), 64'd0);
    check_regs("t3");
    accept_b();
    do_read(32'h100, 1'b0);
    check("t3 oob rdata", 64'(rdata), 64'd0);
    check("t3 oob rresp", 64'(rresp), 64'd2);
    accept_r();

    // Back-pressure on B
    put_wr(32'h8, 32'h0000_0055, 4'hF, 1'b1);
    tick();
    exp_regs[2] = 32'h55;
    check("t4 bvalid", 64'(bvalid), 64'd1);
    put_wr(32'hC, 32'h0000_0066, 4'hF, 1'b0);
    check("t4 awready full", 64'(awready), 64'd0);
    check("t4 wready full", 64'(wready), 64'd0);
    tick();
    tick();
    check("t4 bvalid held", 64'(bvalid), 64'd1);
    check("t4 bid held", 64'(bid), 64'd1);
    check_regs("t4 held");
    accept_b();
    check("t4 bvalid after accept", 64'(bvalid), 64'd0);
    tick();
    exp_regs[3] = 32'h66;
    check("t4 second bvalid", 64'(bvalid), 64'd1);
    check("t4 second bid", 64'(bid), 64'd0);
    check_regs("t4 second");
    accept_b();

    // Read and commit on the same edge
    put_wr(32'h0, 32'h0000_0011, 4'hF, 1'b0);
    tick();
    exp_regs[0] = 32'h11;
    accept_b();
    put_wr(32'h0, 32'h0000_0022, 4'hF, 1'b0);
    do_read(32'h0, 1'b1);
    exp_regs[0] = 32'h22;
    check("t5 same-edge rdata", 64'(rdata), 64'h11);
    check("t5 bvalid", 64'(bvalid), 64'd1);
    check_regs("t5");
    bready = 1'b1;
    accept_r();
    bready = 1'b0;
    do_read(32'h2, 1'b0);
    check("t5 reread rdata", 64'(rdata), 64'h22);
    accept_r();

    // Reset with responses pending and a lone AW held
    put_wr(32'h10, 32'h0000_0077, 4'hF, 1'b1);
    tick();
    do_read(32'h10, 1'b1);
    awvalid = 1'b1; awaddr = 32'h14; awid = 1'b1;
    tick();
    awvalid = 1'b0;
    check("t6 pre bvalid", 64'(bvalid), 64'd1);
    check("t6 pre rvalid", 64'(rvalid), 64'd1);
    areset = 1'b1;
    #1;
    for (int k = 0; k < int'(NR); k++) exp_regs[k] = '0;
    check("t6 bvalid", 64'(bvalid), 64'd0);
    check("t6 rvalid", 64'(rvalid), 64'd0);
    check("t6 bid", 64'(bid), 64'd0);
    check("t6 rid", 64'(rid), 64'd0);
    check("t6 rdata", 64'(rdata), 64'd0);
    check("t6 wr_pulse", 64'(wr_pulse_o), 64'd0);
    check_regs("t6");
    tick();
    areset = 1'b0;
    check("t6 awready", 64'(awready), 64'd1);
    check("t6 wready", 64'(wready), 64'd1);
    check("t6 arready", 64'(arready), 64'd1);
    wvalid = 1'b1; wdata = 32'hCAFE_0000; wstrb = 4'hF;
    tick();
    wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t6 no stale b %0d", i), 64'(bvalid), 64'd0);
      check($sformatf("t6 no stale r %0d", i), 64'(rvalid), 64'd0);
    end
    check_regs("t6 end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/axi_lite_sub_regs.md
# axi_lite_sub_regs

AXI-Lite subordinate that answers a manager on the `axi_lite_if` S-side signal set with a bank of byte-strobed read/write registers plus one read-only status word. It is the responding end of the board's AXI-Lite fabric: the processor or test manager issues transactions, and this block returns B and R responses. Register contents drive board-level outputs such as LEDs and control bits. The status word samples board inputs such as switches and buttons.

## Interface
Parameters:
- ID_WIDTH, 1, width of awid/bid/arid/rid
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data width; 32 or 64 only
- STRB_WIDTH, DATA_WIDTH/8, write-strobe width
- NUM_REGS, 8, number of RW registers; ≥1

Ports:
- aclk  in  1  clock
- areset  in  1  reset; asynchronous, active-high
- awvalid/awready  in/out  1/1  write-address handshake
- awid/awaddr/awprot  in  ID_WIDTH/ADDR_WIDTH/3  write-address payload; awprot ignored
- wvalid/wready  in/out  1/1  write-data handshake
- wdata/wstrb  in  DATA_WIDTH/STRB_WIDTH  write-data payload
- bvalid/bready  out/in  1/1  write-response handshake
- bid/bresp  out  ID_WIDTH/2  write-response payload
- arvalid/arready  in/out  1/1  read-address handshake
- arid/araddr/arprot  in  ID_WIDTH/ADDR_WIDTH/3  read-address payload; arprot ignored
- rvalid/rready  out/in  1/1  read-data handshake
- rid/rdata/rresp  out  ID_WIDTH/DATA_WIDTH/2  read-data payload
- regs_o  out  NUM_REGS*DATA_WIDTH  register contents; reg k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
- wr_pulse_o  out  NUM_REGS  one-cycle pulse when reg k is written
- status_i  in  DATA_WIDTH  read-only status word

## Operation
- Address decode:
  - Index = addr >> log2(STRB_WIDTH). Low address bits are ignored, so unaligned addresses map to their containing word.
  - Index 0..NUM_REGS-1: RW register.
  - Index NUM_REGS: status_i. Reads return OKAY. Writes return SLVERR and change nothing.
  - Any other index: SLVERR. Reads return rdata=0; writes change nothing.
- Write path:
  - AW and W are captured independently into single-entry holding registers (aw_full, w_full). They may arrive in either order or in the same cycle.
  - awready = !aw_full. wready = !w_full.
  - Commit when aw_full && w_full && !bvalid. On the commit edge:
    - byte lanes with wstrb=1 are updated; lanes with wstrb=0 are untouched;
    - wr_pulse_o[idx] is asserted for the following cycle;
    - bvalid, bid=held awid and bresp are set;
    - aw_full and w_full are cleared.
  - wstrb=0 to a valid register: OKAY, no data change, wr_pulse_o still fires.
- Read path:
  - arready = !rvalid.
  - On AR handshake, register rvalid=1, rid=arid, rdata=decoded value and rresp on the same edge.
  - rdata is the register value before that edge. A write committing on the same edge is not visible.
- Response hold: bvalid and rvalid stay high, with payload stable, until bready/rready. They clear on the handshake edge.
- Read and write paths are fully independent and may complete in the same cycle.
- Reset (areset=1, takes effect immediately):
  - regs_o=0, wr_pulse_o=0;
  - bvalid=0, rvalid=0, bid=0, bresp=0, rid=0, rdata=0;
  - aw_full=0, w_full=0, so awready=1 and wready=1.
  - Transactions in flight are dropped with no response.

## Timing
- Write latency: AW and W handshaken at edge N → commit at edge N+1 → bvalid high after N+1.
- Write with AW and W at different edges: commit at the edge after the later handshake.
- Write throughput: at most one write per two cycles. A new AW/W may be accepted on the commit edge's following cycle. The next commit waits for B to be accepted.
- Back-pressure: bready=0 holds bvalid. Further AW and W are still captured (one each), then awready/wready drop.
- Read latency: 1 cycle from AR handshake to rvalid. Throughput is 1 read per 2 cycles; arready is low while rvalid is pending.
- regs_o is registered and updates on the commit edge. wr_pulse_o is high for exactly one cycle after that edge.

## Structure
- Shared package axi_lite_pkg holds:
  - resp_t enum: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11;
  - a helper function for the strobe-merge of one data word.
- Sub-module axi_lite_sub_wr contains the AW/W holding registers, the commit logic and the B channel, and drives a write-enable/index/data/strobe strobe.
- The top level holds the register array, the read path and the decode.

## Test plan
- Reset, then AW and W in the same cycle: addr 0x4, wdata 0xDEADBEEF, wstrb 0xF, awid 1 → bvalid 2 cycles later with bid=1, bresp=OKAY; regs_o reg1=0xDEADBEEF; wr_pulse_o=0x02 for one cycle.
- W before AW by 3 cycles, then wstrb 0x3 with wdata 0x00001234 to reg1 (holding 0xDEADBEEF) → reg1=0xDEAD1234; commit occurs on the edge after the AW handshake.
- Read addr 4*NUM_REGS with status_i=0xA5A5 → rdata=0xA5A5, rresp=OKAY. Write to the same address → SLVERR, no state change. Read addr 0x100 → rdata=0, rresp=SLVERR.
- Hold bready=0 after a write → bvalid and bid stay stable. A second AW and W are captured, then awready=wready=0. Release bready → second bvalid follows.
- Same-cycle AR and write commit to reg0 (old 0x11, new 0x22) → rdata=0x11; a subsequent read returns 0x22.
- Assert areset with bvalid and rvalid pending → all outputs zero immediately; awready=wready=arready=1 after release; no stale response appears.
